gcd_job_sequencer: RTL and testbench

Upstream feeder for the GCD controller/datapath pair. Buffers operand pairs arriving on a valid/ready stream in a small FIFO. Drives them onto the GCD unit's shared load bus: A while ldA is active, B on the following cycle. Waits for done, captures the result, and presents it downstream on a second valid/ready stream, with zero-operand bypass and a hang timeout.

---
 rtl/gcd_job_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_job_sequencer
// Brief    : Queues operand pairs, feeds them to the GCD unit over its shared
//            load bus, and returns results on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_job_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     gcd_start,
    output logic [WIDTH-1:0]         gcd_data_in,
    input  logic                     gcd_done,
    input  logic [WIDTH-1:0]         gcd_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int                c_AW           = $clog2(DEPTH);
    localparam int                c_CW           = $clog2(TIMEOUT) + 1;
    localparam logic [c_CW-1:0]   c_TIMEOUT_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_AW:0]     c_DEPTH        = (c_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;

    logic [WIDTH-1:0]   r_bus;
    logic [c_CW-1:0]    r_wait_cnt;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_err;

    logic               w_ld_bus;
    logic [WIDTH-1:0]   w_bus_val;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_res_ld;
    logic [WIDTH-1:0]   w_res_val;
    logic               w_res_err;

    assign in_ready    = (r_count != c_DEPTH);
    assign w_push      = in_valid & in_ready;
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];
    assign fifo_count  = r_count;

    assign gcd_start   = (r_state == S_LOAD_A);
    assign gcd_data_in = r_bus;
    assign out_valid   = (r_state == S_HOLD);
    assign out_data    = r_out_data;
    assign out_err     = r_out_err;
    assign busy        = (r_state != S_IDLE);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_ld_bus  = 1'b0;
        w_bus_val = w_head_a;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_res_ld  = 1'b0;
        w_res_val = '0;
        w_res_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    // gcd(0,x) = x and gcd(0,0) = 0, so OR gives the answer directly
                    if (w_head_a == '0 || w_head_b == '0) begin
                        w_pop     = 1'b1;
                        w_res_ld  = 1'b1;
                        w_res_val = w_head_a | w_head_b;
                        w_next    = S_HOLD;
                    end else begin
                        w_ld_bus  = 1'b1;
                        w_bus_val = w_head_a;
                        w_next    = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                w_ld_bus  = 1'b1;
                w_bus_val = w_head_b;
                w_next    = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_pop     = 1'b1;
                w_cnt_clr = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_inc = 1'b1;
                // First WAIT cycle (count 0) masks a done left over from the previous job.
                if (r_wait_cnt != '0 && gcd_done) begin
                    w_res_ld  = 1'b1;
                    w_res_val = gcd_result;
                    w_next    = S_HOLD;
                end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_res_ld  = 1'b1;
                    w_res_err = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus      <= '0;
            r_wait_cnt <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            if (w_ld_bus) r_bus <= w_bus_val;
            if (w_cnt_clr) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_res_ld) begin
                r_out_data <= w_res_val;
                r_out_err  <= w_res_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_job_sequencer
// Brief    : Directed self-checking bench for gcd_job_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_job_sequencer;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a = '0;
    logic [WIDTH-1:0]       in_b = '0;
    logic                   gcd_start;
    logic [WIDTH-1:0]       gcd_data_in;
    logic                   gcd_done;
    logic [WIDTH-1:0]       gcd_result;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [WIDTH-1:0]       out_data;
    logic                   out_err;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;

    logic                   resp_en  = 1'b0;
    logic                   r_done   = 1'b0;
    logic [WIDTH-1:0]       r_result = '0;
    logic                   m_done   = 1'b0;
    logic [WIDTH-1:0]       m_result = '0;

    int n_cmp = 0;
    int n_fail = 0;
    int start_cnt = 0;

    assign gcd_done   = resp_en ? r_done   : m_done;
    assign gcd_result = resp_en ? r_result : m_result;

    gcd_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_start(gcd_start), .gcd_data_in(gcd_data_in),
        .gcd_done(gcd_done), .gcd_result(gcd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (gcd_start) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stand-in GCD unit: latches A on the start cycle, B on the next, answers 3 cycles later.
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        forever begin
            @(posedge clk); #1;
            if (resp_en && gcd_start) begin
                ra = gcd_data_in;
                @(posedge clk); #1;
                rb = gcd_data_in;
                repeat (3) begin @(posedge clk); #1; end
                r_done   = 1'b1;
                r_result = gcd_ref(ra, rb);
                @(posedge clk); #1;
                r_done   = 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({gcd_start, out_valid, out_err, busy, in_ready} !== 5'b00001) begin n_fail++; $display("FAIL reset_flags: got %b expected 00001", {gcd_start, out_valid, out_err, busy, in_ready}); end
        n_cmp++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        n_cmp++; if (gcd_data_in !== 16'd0) begin n_fail++; $display("FAIL reset_bus: got %0d expected 0", gcd_data_in); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int s_before;
        int s_after;
        m_done = 1'b0;
        s_before = start_cnt;
        tick(); in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;   // cycle 0
        tick(); in_valid = 1'b0;                                  // cycle 1
        n_cmp++; if (gcd_start !== 1'b0) begin n_fail++; $display("FAIL norm_start_c1: got %0b expected 0", gcd_start); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL norm_count_c1: got %0d expected 1", fifo_count); end
        tick();                                                   // cycle 2
        n_cmp++; if (gcd_start !== 1'b1) begin n_fail++; $display("FAIL norm_start_c2: got %0b expected 1", gcd_start); end
        n_cmp++; if (gcd_data_in !== 16'd48) begin n_fail++; $display("FAIL norm_bus_a: got %0d expected 48", gcd_data_in); end
        tick();                                                   // cycle 3
        n_cmp++; if (gcd_start !== 1'b0) begin n_fail++; $display("FAIL norm_start_c3: got %0b expected 0", gcd_start); end
        n_cmp++; if (gcd_data_in !== 16'd18) begin n_fail++; $display("FAIL norm_bus_b: got %0d expected 18", gcd_data_in); end
        s_after = start_cnt;
        n_cmp++; if (s_after !== s_before + 1) begin n_fail++; $display("FAIL norm_start_count: got %0d expected %0d", s_after - s_before, 1); end
        repeat (8) tick();                                        // cycle 11
        n_cmp++; if ({out_valid, gcd_data_in} !== {1'b0, 16'd18}) begin n_fail++; $display("FAIL norm_wait_c11: got valid=%0b bus=%0d expected valid=0 bus=18", out_valid, gcd_data_in); end
        tick(); m_done = 1'b1; m_result = 16'd6;                  // cycle 12
        tick(); m_done = 1'b0;                                    // cycle 13
        n_cmp++; if ({out_valid, out_err} !== 2'b10) begin n_fail++; $display("FAIL norm_valid: got valid=%0b err=%0b expected valid=1 err=0", out_valid, out_err); end
        n_cmp++; if (out_data !== 16'd6) begin n_fail++; $display("FAIL norm_data: got %0d expected 6", out_data); end
        n_cmp++; if (start_cnt !== s_after) begin n_fail++; $display("FAIL norm_extra_start: got %0d expected %0d", start_cnt, s_after); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;                                 // cycle 14
        n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL norm_release: got valid=%0b busy=%0b expected 0 0", out_valid, busy); end
    endtask

    task automatic test_bypass();
        int sb;
        sb = start_cnt;
        tick(); in_valid = 1'b1; in_a = 16'd0; in_b = 16'd35;     // cycle 0
        tick(); in_a = 16'd0; in_b = 16'd0;                       // cycle 1
        tick(); in_valid = 1'b0;                                  // cycle 2
        n_cmp++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 16'd35}) begin n_fail++; $display("FAIL byp_first: got valid=%0b err=%0b data=%0d expected 1 0 35", out_valid, out_err, out_data); end
        out_ready = 1'b1;
        tick();                                                   // cycle 3
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_gap: got %0b expected 0", out_valid); end
        tick();                                                   // cycle 4
        n_cmp++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 16'd0}) begin n_fail++; $display("FAIL byp_second: got valid=%0b err=%0b data=%0d expected 1 0 0", out_valid, out_err, out_data); end
        tick(); out_ready = 1'b0;                                 // cycle 5
        n_cmp++; if (start_cnt !== sb) begin n_fail++; $display("FAIL byp_no_start: got %0d starts expected 0", start_cnt - sb); end
    endtask

    task automatic test_timeout();
        m_done = 1'b0;
        tick(); in_valid = 1'b1; in_a = 16'd9;  in_b = 16'd6;     // cycle 0
        tick(); in_a = 16'd12; in_b = 16'd8;                      // cycle 1
        tick(); in_valid = 1'b0;                                  // cycle 2
        repeat (17) tick();                                       // cycle 19
        n_cmp++; if ({out_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL to_early: got valid=%0b busy=%0b expected 0 1", out_valid, busy); end
        tick();                                                   // cycle 20
        n_cmp++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b1, 16'd0}) begin n_fail++; $display("FAIL to_result: got valid=%0b err=%0b data=%0d expected 1 1 0", out_valid, out_err, out_data); end
        resp_en = 1'b1;
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL to_next_valid: got %0b expected 1 within 50 cycles", out_valid); end
        n_cmp++; if ({out_err, out_data} !== {1'b0, 16'd4}) begin n_fail++; $display("FAIL to_next_data: got err=%0b data=%0d expected 0 4", out_err, out_data); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        resp_en = 1'b0;
    endtask

    task automatic test_stale_done();
        tick(); in_valid = 1'b1; in_a = 16'd27; in_b = 16'd18;    // cycle 0
        m_done = 1'b1; m_result = 16'd999;
        tick(); in_valid = 1'b0;                                  // cycle 1
        repeat (3) tick();                                        // cycle 4, first WAIT
        tick(); m_result = 16'd9;                                 // cycle 5
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_ignored: got valid=%0b data=%0d expected valid 0", out_valid, out_data); end
        tick(); m_done = 1'b0;                                    // cycle 6
        n_cmp++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 16'd9}) begin n_fail++; $display("FAIL stale_result: got valid=%0b err=%0b data=%0d expected 1 0 9", out_valid, out_err, out_data); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pa  [6] = '{16'd48, 16'd12, 16'd35, 16'd0, 16'd100, 16'd21};
        logic [WIDTH-1:0] pb  [6] = '{16'd18, 16'd8,  16'd14, 16'd9, 16'd75,  16'd6};
        logic [WIDTH-1:0] exp [6] = '{16'd6,  16'd4,  16'd7,  16'd9, 16'd25,  16'd3};
        int got;
        resp_en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); in_valid = 1'b1; in_a = pa[i]; in_b = pb[i]; // cycles 0..4
        end
        tick(); in_a = pa[5]; in_b = pb[5];                       // cycle 5
        repeat (3) tick();                                        // cycle 8
        n_cmp++; if ({out_valid, in_ready, fifo_count} !== {1'b1, 1'b0, 3'd4}) begin n_fail++; $display("FAIL b2b_full: got valid=%0b ready=%0b count=%0d expected 1 0 4", out_valid, in_ready, fifo_count); end
        n_cmp++; if (out_data !== exp[0]) begin n_fail++; $display("FAIL b2b_res0: got %0d expected %0d", out_data, exp[0]); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;                                 // R+1 IDLE
        tick();                                                   // R+2 LOAD_A
        tick();                                                   // R+3 LOAD_B
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_pre: got %0b expected 0", in_ready); end
        tick();                                                   // R+4
        n_cmp++; if ({in_ready, fifo_count} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL b2b_ready_post: got ready=%0b count=%0d expected 1 3", in_ready, fifo_count); end
        tick(); in_valid = 1'b0;                                  // R+5
        n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_pair6: got count=%0d expected 4", fifo_count); end
        out_ready = 1'b1;
        got = 1;
        for (int c = 0; c < 500 && got < 6; c++) begin
            tick();
            if (out_valid === 1'b1) begin
                n_cmp++; if ({out_err, out_data} !== {1'b0, exp[got]}) begin n_fail++; $display("FAIL b2b_res%0d: got err=%0b data=%0d expected 0 %0d", got, out_err, out_data, exp[got]); end
                got++;
            end
        end
        n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 6", got); end
        tick(); out_ready = 1'b0;
        resp_en = 1'b0;
    endtask

    task automatic test_reset_midwait();
        logic [WIDTH-1:0] qa [4] = '{16'd5, 16'd7, 16'd9, 16'd11};
        logic [WIDTH-1:0] qb [4] = '{16'd3, 16'd2, 16'd4, 16'd5};
        m_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); in_valid = 1'b1; in_a = qa[i]; in_b = qb[i]; // cycles 0..3
        end
        tick(); in_valid = 1'b0;                                  // cycle 4
        repeat (2) tick();                                        // cycle 6
        n_cmp++; if ({busy, fifo_count} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL rstw_pre: got busy=%0b count=%0d expected 1 3", busy, fifo_count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({gcd_start, out_valid, out_err, busy, in_ready} !== 5'b00001) begin n_fail++; $display("FAIL rstw_flags: got %b expected 00001", {gcd_start, out_valid, out_err, busy, in_ready}); end
        n_cmp++; if ({out_data, gcd_data_in, fifo_count} !== {16'd0, 16'd0, 3'd0}) begin n_fail++; $display("FAIL rstw_regs: got data=%0d bus=%0d count=%0d expected 0 0 0", out_data, gcd_data_in, fifo_count); end
        tick(); rst = 1'b0;
        resp_en = 1'b1;
        tick(); in_valid = 1'b1; in_a = 16'd12; in_b = 16'd8;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick();
        n_cmp++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 16'd4}) begin n_fail++; $display("FAIL rstw_after: got valid=%0b err=%0b data=%0d expected 1 0 4", out_valid, out_err, out_data); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        n_cmp++; if ({busy, fifo_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rstw_idle: got busy=%0b count=%0d expected 0 0", busy, fifo_count); end
        resp_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bypass();
        test_timeout();
        test_stale_done();
        test_back_to_back();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
